// File: rtl/apb_requester_if.sv
// Bus bundle for apb_requester: core-side command/response handshakes plus the APB completer-facing signals.
// The master modport is the requester's view; the slave modport is the view of whatever surrounds it.
interface apb_requester_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    // command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_write;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_strobe;

    // response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    // APB
    logic [ADDR_W-1:0] Paddr;
    logic              Psel;
    logic              Penable;
    logic              Pwrite;
    logic [DATA_W-1:0] Pwdata;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] Prdata;
    logic              Pready;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strobe,
        input  rsp_ready, Prdata, Pready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output Paddr, Psel, Penable, Pwrite, Pwdata, strobe
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strobe,
        output rsp_ready, Prdata, Pready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  Paddr, Psel, Penable, Pwrite, Pwdata, strobe
    );
endinterface

// File: rtl/apb_requester.sv
// Single-outstanding APB requester: takes one command, runs SETUP/ACCESS, and returns data/status on the
// response channel. A wait-state watchdog aborts an ACCESS phase that a completer never finishes.
module apb_requester #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 8
) (
    input  logic           clock,
    input  logic           reset,
    apb_requester_if.master bus
);
    localparam int STRB_W = DATA_W / 8;
    // The watchdog fires on the TIMEOUT-th low-Pready ACCESS cycle, when the counter still shows TIMEOUT-1.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit WDOG_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strobe;
        logic              sel;
        logic              enable;
    } apb_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rdata;
        logic              err;
    } rsp_t;

    state_t            state, state_nxt;
    apb_t              apb, apb_nxt;
    rsp_t              rsp, rsp_nxt;
    logic              cmd_ready, cmd_ready_nxt;
    logic [TO_W-1:0]   wdog, wdog_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            apb       <= '0;
            rsp       <= '0;
            cmd_ready <= 1'b1;
            wdog      <= '0;
        end else begin
            state     <= state_nxt;
            apb       <= apb_nxt;
            rsp       <= rsp_nxt;
            cmd_ready <= cmd_ready_nxt;
            wdog      <= wdog_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        apb_nxt       = apb;
        rsp_nxt       = rsp;
        cmd_ready_nxt = cmd_ready;
        wdog_nxt      = wdog;

        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_nxt      = SETUP;
                    cmd_ready_nxt  = 1'b0;
                    apb_nxt.addr   = bus.cmd_addr;
                    apb_nxt.write  = bus.cmd_write;
                    // reads drive zero data and strobes on the bus
                    apb_nxt.wdata  = bus.cmd_write ? bus.cmd_wdata  : '0;
                    apb_nxt.strobe = bus.cmd_write ? bus.cmd_strobe : '0;
                    apb_nxt.sel    = 1'b1;
                    apb_nxt.enable = 1'b0;
                end
            end

            SETUP: begin
                state_nxt      = ACCESS;
                apb_nxt.enable = 1'b1;
            end

            ACCESS: begin
                if (bus.Pready) begin
                    state_nxt      = RESP;
                    apb_nxt.sel    = 1'b0;
                    apb_nxt.enable = 1'b0;
                    rsp_nxt.valid  = 1'b1;
                    rsp_nxt.rdata  = apb.write ? '0 : bus.Prdata;
                    rsp_nxt.err    = 1'b0;
                    wdog_nxt       = '0;
                end else if (WDOG_EN && (wdog == TO_LAST)) begin
                    state_nxt      = RESP;
                    apb_nxt.sel    = 1'b0;
                    apb_nxt.enable = 1'b0;
                    rsp_nxt.valid  = 1'b1;
                    rsp_nxt.rdata  = '0;
                    rsp_nxt.err    = 1'b1;
                    wdog_nxt       = '0;
                end else begin
                    wdog_nxt = wdog + 1'b1;
                end
            end

            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt     = IDLE;
                    rsp_nxt.valid = 1'b0;
                    cmd_ready_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt     = IDLE;
                cmd_ready_nxt = 1'b1;
            end
        endcase
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp.valid;
    assign bus.rsp_rdata = rsp.rdata;
    assign bus.rsp_err   = rsp.err;
    assign bus.Paddr     = apb.addr;
    assign bus.Psel      = apb.sel;
    assign bus.Penable   = apb.enable;
    assign bus.Pwrite    = apb.write;
    assign bus.Pwdata    = apb.wdata;
    assign bus.strobe    = apb.strobe;
endmodule
